// File: rtl/cache_l1_param.sv
`default_nettype none
// cache_l1_param: parametrised direct-mapped write-through L1 data cache with
// optional write-miss allocate and saturating read hit/miss counters.
module cache_l1_param #(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int WRITE_ALLOCATE = 0,
  parameter int CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             proc_reset,
  input  logic                             proc_read,
  input  logic                             proc_write,
  input  logic [ADDR_W-1:0]                proc_addr,
  input  logic [DATA_W-1:0]                proc_wdata,
  output logic                             proc_stall,
  output logic [DATA_W-1:0]                proc_rdata,
  output logic                             L2_read,
  output logic                             L2_write,
  output logic [ADDR_W-1:0]                L2_addr,
  output logic [DATA_W-1:0]                L2_wdata,
  input  logic [DATA_W*WORDS_PER_LINE-1:0] L2_rdata,
  input  logic                             L2_ready,
  output logic [CNT_W-1:0]                 rd_hit_cnt,
  output logic [CNT_W-1:0]                 rd_miss_cnt
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [DATA_W-1:0]    data [NUM_LINES][WORDS_PER_LINE];
  logic [DATA_W-1:0]    fill_word [WORDS_PER_LINE];

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             hit_inc, miss_inc, fill_en, word_en;

  assign offset   = proc_addr[OFF_W-1:0];
  assign index    = proc_addr[OFF_W+IDX_W-1:OFF_W];
  assign tag      = proc_addr[ADDR_W-1:OFF_W+IDX_W];
  assign hit      = valid[index] && (tags[index] == tag);
  assign L2_wdata = proc_wdata;

  generate
    for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_fill
      assign fill_word[k] = L2_rdata[k*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    state_nxt  = state;
    proc_stall = 1'b0;
    proc_rdata = '0;
    L2_read    = 1'b0;
    L2_write   = 1'b0;
    L2_addr    = '0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    fill_en    = 1'b0;
    word_en    = 1'b0;
    case (state)
      IDLE: begin
        // A simultaneous read and write is served as a write.
        if (proc_write) begin
          proc_stall = 1'b1;
          state_nxt  = (!hit && (WRITE_ALLOCATE != 0)) ? REFILL : WRITE;
        end else if (proc_read) begin
          if (hit) begin
            proc_rdata = data[index][offset];
            hit_inc    = 1'b1;
          end else begin
            proc_stall = 1'b1;
            miss_inc   = 1'b1;
            state_nxt  = REFILL;
          end
        end
      end
      REFILL: begin
        L2_read    = 1'b1;
        L2_addr    = {proc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        proc_stall = 1'b1;
        if (L2_ready) begin
          fill_en = 1'b1;
          if (proc_write) begin
            state_nxt = WRITE;
          end else begin
            proc_stall = 1'b0;
            proc_rdata = fill_word[offset];
            state_nxt  = IDLE;
          end
        end
      end
      WRITE: begin
        L2_write   = 1'b1;
        L2_addr    = proc_addr;
        proc_stall = 1'b1;
        if (L2_ready) begin
          proc_stall = 1'b0;
          word_en    = hit;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state       <= IDLE;
      valid       <= '0;
      rd_hit_cnt  <= '0;
      rd_miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (fill_en) valid[index] <= 1'b1;
      if (hit_inc && (rd_hit_cnt != '1)) rd_hit_cnt <= rd_hit_cnt + CNT_W'(1);
      if (miss_inc && (rd_miss_cnt != '1)) rd_miss_cnt <= rd_miss_cnt + CNT_W'(1);
    end
  end

  // Tags and data are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[index] <= tag;
      for (int k = 0; k < WORDS_PER_LINE; k++) data[index][k] <= fill_word[k];
    end
    if (word_en) data[index][offset] <= proc_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_l1_param.sv
`default_nettype none
// tb_cache_l1_param: two cache instances (no-allocate/16-bit counters and
// allocate/2-bit counters) checked against a transaction-level cache model.
module tb_cache_l1_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2], rd [2], wr [2];
  logic [29:0] addr [2];
  logic [31:0] wdat [2];
  logic        stall [2];
  logic [31:0] rdata [2];
  logic        l2r [2], l2w [2], l2rdy [2];
  logic [29:0] l2a [2];
  logic [31:0] l2wd [2];
  logic [127:0] l2rd [2];
  logic [15:0] hit0, miss0;
  logic [1:0]  hit1, miss1;

  cache_l1_param #(.WRITE_ALLOCATE(0), .CNT_W(16)) dut0 (
    .clk(clk), .proc_reset(rst[0]), .proc_read(rd[0]), .proc_write(wr[0]),
    .proc_addr(addr[0]), .proc_wdata(wdat[0]), .proc_stall(stall[0]),
    .proc_rdata(rdata[0]), .L2_read(l2r[0]), .L2_write(l2w[0]), .L2_addr(l2a[0]),
    .L2_wdata(l2wd[0]), .L2_rdata(l2rd[0]), .L2_ready(l2rdy[0]),
    .rd_hit_cnt(hit0), .rd_miss_cnt(miss0));

  cache_l1_param #(.WRITE_ALLOCATE(1), .CNT_W(2)) dut1 (
    .clk(clk), .proc_reset(rst[1]), .proc_read(rd[1]), .proc_write(wr[1]),
    .proc_addr(addr[1]), .proc_wdata(wdat[1]), .proc_stall(stall[1]),
    .proc_rdata(rdata[1]), .L2_read(l2r[1]), .L2_write(l2w[1]), .L2_addr(l2a[1]),
    .L2_wdata(l2wd[1]), .L2_rdata(l2rd[1]), .L2_ready(l2rdy[1]),
    .rd_hit_cnt(hit1), .rd_miss_cnt(miss1));

  // Model: line contents per instance plus an L2 backing store.
  bit          m_valid [2][8];
  logic [24:0] m_tag [2][8];
  logic [31:0] m_data [2][8][4];
  int          m_hits [2], m_miss [2];
  logic [31:0] l2mem [longint];

  bit          chk_en;
  bit          e_stall [2], e_l2r [2], e_l2w [2], e_rdv [2];
  logic [29:0] e_addr [2];
  logic [31:0] e_rdata [2];
  int          n_cmp, n_fail;

  function automatic longint key(input int d, input logic [29:0] a);
    return longint'({d[0], a});
  endfunction

  function automatic logic [31:0] l2_word(input int d, input logic [29:0] a);
    if (l2mem.exists(key(d, a))) return l2mem[key(d, a)];
    return {2'b01, a};
  endfunction

  function automatic int sat(input int v, input int d);
    return (v == ((d == 0) ? 65535 : 3)) ? v : v + 1;
  endfunction

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", n, act, exp);
    end
  endtask

  task automatic setexp(input int d, input bit s, input bit r, input bit w,
                        input logic [29:0] a, input bit rv, input logic [31:0] rdv);
    e_stall[d] = s; e_l2r[d] = r; e_l2w[d] = w; e_addr[d] = a;
    e_rdv[d] = rv; e_rdata[d] = rdv;
  endtask

  task automatic idle(input int d);
    setexp(d, 1'b0, 1'b0, 1'b0, 30'd0, 1'b1, 32'd0);
  endtask

  task automatic step(input int d, output logic [31:0] got);
    @(negedge clk);
    got = rdata[d];
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 8; i++) m_valid[d][i] = 1'b0;
    m_hits[d] = 0;
    m_miss[d] = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d stall", d), 64'(stall[d]), 64'(e_stall[d]));
        check($sformatf("d%0d L2_read", d), 64'(l2r[d]), 64'(e_l2r[d]));
        check($sformatf("d%0d L2_write", d), 64'(l2w[d]), 64'(e_l2w[d]));
        if (e_l2r[d] || e_l2w[d]) check($sformatf("d%0d L2_addr", d), 64'(l2a[d]), 64'(e_addr[d]));
        if (e_l2w[d]) check($sformatf("d%0d L2_wdata", d), 64'(l2wd[d]), 64'(wdat[d]));
        if (e_rdv[d]) check($sformatf("d%0d rdata", d), 64'(rdata[d]), 64'(e_rdata[d]));
        check($sformatf("d%0d hit_cnt", d), (d == 0) ? 64'(hit0) : 64'(hit1), 64'(m_hits[d]));
        check($sformatf("d%0d miss_cnt", d), (d == 0) ? 64'(miss0) : 64'(miss1), 64'(m_miss[d]));
      end
    end
  end

  // One processor transaction; lat1 = refill cycles, lat2 = write cycles,
  // the L2_ready pulse landing in the last cycle of each.
  task automatic access(input int d, input bit w, input bit rd_too, input logic [29:0] a,
                        input logic [31:0] wd, input int lat1, input int lat2,
                        output logic [31:0] got);
    int          idx, off;
    logic [24:0] tg;
    logic [29:0] base;
    logic [31:0] fillw [4];
    bit          hit, last;
    idx  = int'((a / 30'd4) % 30'd8);
    off  = int'(a % 30'd4);
    tg   = 25'(a / 30'd32);
    base = a - (a % 30'd4);
    hit  = m_valid[d][idx] && (m_tag[d][idx] == tg);
    rd[d] = !w || rd_too; wr[d] = w; addr[d] = a; wdat[d] = wd;
    if (!w && hit) begin
      setexp(d, 1'b0, 1'b0, 1'b0, 30'd0, 1'b1, m_data[d][idx][off]);
      step(d, got);
      m_hits[d] = sat(m_hits[d], d);
    end else begin
      setexp(d, 1'b1, 1'b0, 1'b0, 30'd0, 1'b0, 32'd0);
      step(d, got);
      if (!w) m_miss[d] = sat(m_miss[d], d);
      if (!w || (!hit && d == 1)) begin
        for (int k = 0; k < 4; k++) begin
          fillw[k] = l2_word(d, 30'(base + 30'(k)));
          l2rd[d][k*32 +: 32] = fillw[k];
        end
        for (int c = 1; c <= lat1; c++) begin
          last = (c == lat1);
          l2rdy[d] = last;
          setexp(d, !(last && !w), 1'b1, 1'b0, base, last && !w, fillw[off]);
          step(d, got);
        end
        l2rdy[d] = 1'b0;
        l2rd[d] = '0;
        m_valid[d][idx] = 1'b1;
        m_tag[d][idx] = tg;
        for (int k = 0; k < 4; k++) m_data[d][idx][k] = fillw[k];
      end
      if (w) begin
        for (int c = 1; c <= lat2; c++) begin
          last = (c == lat2);
          l2rdy[d] = last;
          setexp(d, !last, 1'b0, 1'b1, a, 1'b0, 32'd0);
          step(d, got);
        end
        l2rdy[d] = 1'b0;
        l2mem[key(d, a)] = wd;
        if (m_valid[d][idx] && m_tag[d][idx] == tg) m_data[d][idx][off] = wd;
      end
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    idle(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    chk_en = 1'b0; n_cmp = 0; n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdat[d] = '0;
      l2rdy[d] = 1'b0; l2rd[d] = '0;
      model_reset(d);
      idle(d);
      l2mem[key(d, 30'h10)] = 32'hA; l2mem[key(d, 30'h11)] = 32'hB;
      l2mem[key(d, 30'h12)] = 32'hC; l2mem[key(d, 30'h13)] = 32'hD;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(0, g);
    rst[0] = 1'b0; rst[1] = 1'b0;
    step(0, g);

    // Instance 0: no allocate.
    access(0, 1'b0, 1'b0, 30'h10, 32'h0, 3, 0, g);
    check("t1 rdata", 64'(g), 64'hA);
    check("t1 miss_cnt", 64'(miss0), 64'd1);
    access(0, 1'b0, 1'b0, 30'h13, 32'h0, 0, 0, g);
    check("t2 rdata", 64'(g), 64'hD);
    check("t2 hit_cnt", 64'(hit0), 64'd1);
    access(0, 1'b1, 1'b0, 30'h11, 32'h55, 0, 2, g);
    access(0, 1'b0, 1'b0, 30'h11, 32'h0, 0, 0, g);
    check("t3 rdata", 64'(g), 64'h55);
    access(0, 1'b1, 1'b0, 30'h30, 32'h77, 0, 2, g);
    access(0, 1'b0, 1'b0, 30'h30, 32'h0, 2, 0, g);
    check("t4 rdata", 64'(g), 64'h77);
    access(0, 1'b0, 1'b0, 30'h10, 32'h0, 1, 0, g);
    check("t5 rdata", 64'(g), 64'hA);
    access(0, 1'b0, 1'b0, 30'h30, 32'h0, 2, 0, g);
    access(0, 1'b0, 1'b0, 30'h10, 32'h0, 1, 0, g);
    check("t5 miss_cnt", 64'(miss0), 64'd5);
    check("t5 hit_cnt", 64'(hit0), 64'd2);
    access(0, 1'b0, 1'b0, 30'h3FFF_FFFF, 32'h0, 1, 0, g);
    check("top addr rdata", 64'(g), 64'h7FFF_FFFF);

    // Reset in the middle of a refill.
    rd[0] = 1'b1; addr[0] = 30'h50;
    setexp(0, 1'b1, 1'b0, 1'b0, 30'd0, 1'b0, 32'd0);
    step(0, g);
    m_miss[0] = sat(m_miss[0], 0);
    setexp(0, 1'b1, 1'b1, 1'b0, 30'h50, 1'b0, 32'd0);
    step(0, g);
    #2;
    rst[0] = 1'b1;
    model_reset(0);
    setexp(0, 1'b1, 1'b0, 1'b0, 30'd0, 1'b0, 32'd0);
    @(negedge clk);
    check("rst L2_read", 64'(l2r[0]), 64'd0);
    check("rst miss_cnt", 64'(miss0), 64'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0; rd[0] = 1'b0;
    idle(0);
    l2rdy[0] = 1'b1; l2rd[0] = '1;
    step(0, g);
    l2rdy[0] = 1'b0; l2rd[0] = '0;
    access(0, 1'b0, 1'b0, 30'h10, 32'h0, 2, 0, g);
    check("post-rst rdata", 64'(g), 64'hA);
    check("post-rst miss_cnt", 64'(miss0), 64'd1);

    // Instance 1: write allocate, 2-bit counters.
    access(1, 1'b1, 1'b0, 30'h30, 32'h77, 2, 3, g);
    access(1, 1'b0, 1'b0, 30'h30, 32'h0, 0, 0, g);
    check("alloc rdata", 64'(g), 64'h77);
    check("alloc miss_cnt", 64'(miss1), 64'd0);
    access(1, 1'b0, 1'b0, 30'h31, 32'h0, 0, 0, g);
    access(1, 1'b0, 1'b0, 30'h32, 32'h0, 0, 0, g);
    access(1, 1'b0, 1'b0, 30'h33, 32'h0, 0, 0, g);
    access(1, 1'b0, 1'b0, 30'h30, 32'h0, 0, 0, g);
    check("sat hit_cnt", 64'(hit1), 64'd3);
    access(1, 1'b1, 1'b1, 30'h31, 32'h99, 0, 1, g);
    access(1, 1'b0, 1'b0, 30'h31, 32'h0, 0, 0, g);
    check("rw-both rdata", 64'(g), 64'h99);

    step(0, g);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_l1_param.md
Name: cache_l1_param

Overview:
Parametrised direct-mapped, write-through L1 data cache between the processor port and the L2 port. Successor to the fixed 8-line, 4-word L1: line count, words per line and data width are parameters. A write-miss allocate mode is selectable, and read hit/miss counters are added. Read misses refill a full line from L2. Every write is forwarded to L2 as a single-word write.

Parameters:
ADDR_W, 30, processor word-address width
DATA_W, 32, word width in bits
NUM_LINES, 8, cache lines; power of two, at least 2
WORDS_PER_LINE, 4, words per line; power of two, at least 2
WRITE_ALLOCATE, 0, 1 = write miss refills the line before the L2 write; 0 = no allocate
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock; all state updates on the rising edge
proc_reset  in  1  asynchronous active-high reset
proc_read  in  1  processor read request, held until stall is low
proc_write  in  1  processor write request, held until stall is low
proc_addr  in  ADDR_W  word address
proc_wdata  in  DATA_W  write data
proc_stall  out  1  high while the request is not complete
proc_rdata  out  DATA_W  read data, valid in the cycle stall is low with proc_read high
L2_read  out  1  line refill request
L2_write  out  1  single-word write request
L2_addr  out  ADDR_W  refill: line-aligned address (offset bits 0); write: proc_addr
L2_wdata  out  DATA_W  equals proc_wdata
L2_rdata  in  DATA_W*WORDS_PER_LINE  refill line; word k occupies bits [k*DATA_W +: DATA_W]
L2_ready  in  1  one-cycle completion pulse for the current L2 request
rd_hit_cnt  out  CNT_W  saturating count of read hits
rd_miss_cnt  out  CNT_W  saturating count of read misses

Behaviour:
- Address split: OFF_W = log2(WORDS_PER_LINE) and IDX_W = log2(NUM_LINES).
  - offset = addr[OFF_W-1:0]
  - index = addr[OFF_W+IDX_W-1:OFF_W]
  - tag = the remaining upper bits
- Hit = valid[index] and tag match.
- Storage per line: valid bit, tag, data. No dirty bit, because the cache is write-through.
- Reset: asynchronous, active-high, takes effect immediately.
  - state = IDLE, all valid bits = 0, both counters = 0.
  - All outputs derive combinationally from state, so L2_read and L2_write drop at once. Data arrays need not be cleared.
  - An outstanding L2 transaction is abandoned; an L2_ready arriving after reset is ignored in IDLE.
- Output values in IDLE with no request: proc_stall=0, proc_rdata=0, L2_read=0, L2_write=0.
- States: IDLE, REFILL, WRITE.
- IDLE:
  - Read hit: proc_stall=0 and proc_rdata = selected word in the same cycle (zero latency). rd_hit_cnt increments.
  - Read miss: proc_stall=1, next state REFILL, rd_miss_cnt increments once.
  - Write, any hit status: proc_stall=1. Next state is REFILL if miss and WRITE_ALLOCATE=1, otherwise WRITE.
  - proc_read and proc_write both high: treated as a write.
- REFILL:
  - L2_read=1 and L2_addr = line-aligned address. proc_stall=1 until L2_ready.
  - On L2_ready: load the line from L2_rdata, set tag, set valid.
    - For a read: proc_stall=0 and proc_rdata = word[offset] taken from L2_rdata that same cycle, then return to IDLE.
    - For an allocating write: proc_stall stays 1, next state WRITE.
  - Neither counter changes in REFILL.
- WRITE:
  - L2_write=1, L2_addr=proc_addr, L2_wdata=proc_wdata.
  - On L2_ready: if the line hits, replace word[offset] with proc_wdata. Then proc_stall=0 that cycle and return to IDLE.
  - A write miss with WRITE_ALLOCATE=0 leaves the cache unchanged.
- Every L2 request is held until L2_ready; there is no timeout. proc_addr, proc_wdata and the request lines must stay stable while proc_stall=1.
- L2_ready asserted in IDLE is ignored.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Latencies: read hit 0 stall cycles; read miss = L2 latency (stall released in the L2_ready cycle); write = L2 latency; allocating write miss = two L2 latencies.

Test Plan:
1. Reset, then read addr 0x10 (index 4, offset 0); L2 returns line {0xD,0xC,0xB,0xA} after 3 cycles -> L2_read high with L2_addr=0x10; stall released in the ready cycle; rdata=0xA; rd_miss_cnt=1.
2. Then read 0x13 -> same-cycle hit, rdata=0xD, rd_hit_cnt=1, no L2 activity.
3. Write 0x11 with data 0x55, L2_ready after 2 cycles -> L2_write with addr 0x11; cache word updated; a following read of 0x11 hits with 0x55.
4. WRITE_ALLOCATE=0: write 0x30 (miss), then read 0x30 -> read misses and refills. WRITE_ALLOCATE=1: the same write refills line 0x30 first, then writes; the read then hits with the new data.
5. Conflict: read 0x10, then read 0x30 (same index, new tag) -> second access misses and evicts; re-reading 0x10 misses again.
6. Assert proc_reset mid-REFILL -> L2_read=0 immediately; counters=0; after reset, a read of 0x10 misses; a stale L2_ready is ignored. CNT_W=2 with 5 hits -> rd_hit_cnt=3.
